// File: rtl/bomberman_pkg.sv
// Shared playfield geometry, FSM encodings and the tile-snap helper used by
// the bomb controller (and by the enemy/bomberman blocks).
package bomberman_pkg;

    // Playfield bounds in VGA pixel coordinates
    localparam logic [9:0] MIN_X = 10'd143;
    localparam logic [9:0] MAX_X = 10'd784;
    localparam logic [9:0] MIN_Y = 10'd34;
    localparam logic [9:0] MAX_Y = 10'd516;

    localparam int TILE = 16;

    // Blast plus geometry: horizontal bar spans x in [e_x-E_WN, e_x+E_WP],
    // vertical bar spans y in [e_y-E_HP, e_y+E_HN]; both bars are E_Width thick.
    localparam int E_WN    = 48;
    localparam int E_WP    = 63;
    localparam int E_HP    = 48;
    localparam int E_HN    = 63;
    localparam int E_Width = 16;

    // Highest tile index on each axis (40 x 30 tile grid)
    localparam logic [5:0] MAX_CX = 6'd39;
    localparam logic [5:0] MAX_CY = 6'd29;

    // Controller state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FUSE  = 2'd1;
    localparam logic [1:0] ST_BLAST = 2'd2;

    // Snap a sprite top-left coordinate to the tile under its centre, clamped
    // to the grid. 11-bit math keeps p+8 from wrapping.
    function automatic logic [9:0] snap(input logic [9:0] p, input logic [9:0] lo,
                                        input logic [5:0] max_idx);
        logic [10:0] s;
        logic [10:0] c;
        s = {1'b0, p} + 11'd8;
        if (s >= {1'b0, lo}) c = (s - {1'b0, lo}) >> 4;
        else                 c = '0;
        if (c > {5'b0, max_idx}) c = {5'b0, max_idx};
        return 10'({1'b0, lo} + (c << 4));
    endfunction

endpackage

// File: rtl/bomb_controller_if.sv
// Player/VGA side bundle of the bomb controller.
interface bomb_controller_if;
    logic       place_btn;
    logic       game_over;
    logic [9:0] b_x;
    logic [9:0] b_y;
    logic [9:0] v_x;
    logic [9:0] v_y;
    logic [9:0] e_x;
    logic [9:0] e_y;
    logic       explosion_SCEN;
    logic       blast_active;
    logic       bomb_on;
    logic       explosion_on;
    logic       player_hit;

    modport master (
        output place_btn, game_over, b_x, b_y, v_x, v_y,
        input  e_x, e_y, explosion_SCEN, blast_active, bomb_on, explosion_on, player_hit
    );

    modport slave (
        input  place_btn, game_over, b_x, b_y, v_x, v_y,
        output e_x, e_y, explosion_SCEN, blast_active, bomb_on, explosion_on, player_hit
    );
endinterface

// File: rtl/blast_overlap.sv
// Combinational test: does box [x, x+W-1] x [y, y+H-1] touch the blast plus
// centred on tile (e_x, e_y)? Offsets go on the opposite side of each compare
// so nothing underflows.
module blast_overlap
    import bomberman_pkg::*;
#(
    parameter int W = 16,
    parameter int H = 16
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] e_x,
    input  logic [9:0] e_y,
    output logic       hit
);
    logic [11:0] xl, xr, yt, yb, ex, ey;
    logic        h_bar, v_bar;

    assign xl = {2'b0, x};
    assign yt = {2'b0, y};
    assign xr = xl + 12'(W - 1);
    assign yb = yt + 12'(H - 1);
    assign ex = {2'b0, e_x};
    assign ey = {2'b0, e_y};

    assign h_bar = (xl <= ex + 12'(E_WP)) && (xr + 12'(E_WN) >= ex) &&
                   (yt <= ey + 12'(E_Width - 1)) && (yb >= ey);
    assign v_bar = (xl <= ex + 12'(E_Width - 1)) && (xr >= ex) &&
                   (yt <= ey + 12'(E_HN)) && (yb + 12'(E_HP) >= ey);

    assign hit = h_bar || v_bar;
endmodule

// File: rtl/bomb_controller.sv
// Single-bomb controller: latches a snapped bomb tile on a place press, runs
// FUSE then BLAST on a cycle counter, strobes the explosion to enemies, keeps
// a sticky player-hit flag and flags VGA pixels for the bomb/blast sprites.
module bomb_controller
    import bomberman_pkg::*;
#(
    parameter int FUSE_CYCLES  = 200_000_000,
    parameter int BLAST_CYCLES = 50_000_000,
    parameter int CNT_W        = 28
) (
    input  logic               clk,
    input  logic               reset,
    bomb_controller_if.slave   bus
);
    localparam logic [CNT_W-1:0] FUSE_LAST  = CNT_W'(FUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLAST_LAST = CNT_W'(BLAST_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             btn_prev;
    logic [9:0]       e_x, e_y;
    logic             scen;
    logic             hit;
    logic             press;
    logic             player_ov;
    logic             pixel_ov;
    logic             in_tile;
    logic [10:0]      vx, vy, ex, ey;

    assign press = bus.place_btn && !btn_prev;

    blast_overlap #(.W(16), .H(16)) u_player (
        .x(bus.b_x), .y(bus.b_y), .e_x(e_x), .e_y(e_y), .hit(player_ov)
    );

    blast_overlap #(.W(1), .H(1)) u_pixel (
        .x(bus.v_x), .y(bus.v_y), .e_x(e_x), .e_y(e_y), .hit(pixel_ov)
    );

    // Phase sequencing, placement latch, explosion strobe and sticky hit flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            btn_prev <= 1'b0;
            e_x      <= MIN_X;
            e_y      <= MIN_Y;
            scen     <= 1'b0;
            hit      <= 1'b0;
        end else begin
            btn_prev <= bus.place_btn;
            scen     <= 1'b0;
            if (state == ST_BLAST && player_ov) hit <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (press && !bus.game_over) begin
                        e_x   <= snap(bus.b_x, MIN_X, MAX_CX);
                        e_y   <= snap(bus.b_y, MIN_Y, MAX_CY);
                        cnt   <= '0;
                        state <= ST_FUSE;
                    end
                end
                ST_FUSE: begin
                    if (cnt == FUSE_LAST) begin
                        cnt   <= '0;
                        scen  <= 1'b1;
                        state <= ST_BLAST;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BLAST: begin
                    if (cnt == BLAST_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pixel inside the 16x16 bomb tile
    assign vx = {1'b0, bus.v_x};
    assign vy = {1'b0, bus.v_y};
    assign ex = {1'b0, e_x};
    assign ey = {1'b0, e_y};
    assign in_tile = (vx >= ex) && (vx <= ex + 11'd15) && (vy >= ey) && (vy <= ey + 11'd15);

    assign bus.e_x            = e_x;
    assign bus.e_y            = e_y;
    assign bus.explosion_SCEN = scen;
    assign bus.blast_active   = (state == ST_BLAST);
    assign bus.bomb_on        = (state == ST_FUSE) && in_tile;
    assign bus.explosion_on   = (state == ST_BLAST) && pixel_ov;
    assign bus.player_hit     = hit;
endmodule

// File: tb/tb_bomb_controller.sv
// Scoreboard bench for bomb_controller with FUSE_CYCLES=10, BLAST_CYCLES=5.
// Stimulus queues cycle-tagged expectations; a negedge monitor checks them
// and separately checks every explosion strobe against its expected cycle.
module tb_bomb_controller;
    localparam int S_EX = 0, S_EY = 1, S_SCEN = 2, S_BLAST = 3, S_HIT = 4, S_BOMB = 5, S_EXPL = 6;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    int   scen_q[$];

    bomb_controller_if bif();

    bomb_controller #(.FUSE_CYCLES(10), .BLAST_CYCLES(5), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(input int s);
        case (s)
            S_EX:    return "e_x";
            S_EY:    return "e_y";
            S_SCEN:  return "explosion_SCEN";
            S_BLAST: return "blast_active";
            S_HIT:   return "player_hit";
            S_BOMB:  return "bomb_on";
            default: return "explosion_on";
        endcase
    endfunction

    function automatic int sig_val(input int s);
        case (s)
            S_EX:    return int'(bif.e_x);
            S_EY:    return int'(bif.e_y);
            S_SCEN:  return int'(bif.explosion_SCEN);
            S_BLAST: return int'(bif.blast_active);
            S_HIT:   return int'(bif.player_hit);
            S_BOMB:  return int'(bif.bomb_on);
            default: return int'(bif.explosion_on);
        endcase
    endfunction

    task automatic expect_at(input int c, input int s, input int v);
        exp_q.push_back('{c, s, v});
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic press_now();
        bif.place_btn = 1'b1;
        step();
        bif.place_btn = 1'b0;
    endtask

    // Monitor: checks queued expectations for this cycle and every strobe seen
    always @(negedge clk) begin
        int i;
        int act;
        int t;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].cyc == cyc) begin
                act = sig_val(exp_q[i].sig);
                tests++;
                if (act != exp_q[i].val) begin
                    fails++;
                    $display("FAIL %s @cycle %0d: got %0d, expected %0d",
                             sig_name(exp_q[i].sig), cyc, act, exp_q[i].val);
                end
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
        if (bif.explosion_SCEN === 1'b1) begin
            tests++;
            if (scen_q.size() == 0) begin
                fails++;
                $display("FAIL scen_unexpected @cycle %0d: got strobe, expected none", cyc);
            end else begin
                t = scen_q.pop_front();
                if (t != cyc) begin
                    fails++;
                    $display("FAIL scen_cycle: got cycle %0d, expected cycle %0d", cyc, t);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        bif.place_btn = 1'b0;
        bif.game_over = 1'b0;
        bif.b_x = 10'd0;
        bif.b_y = 10'd0;
        bif.v_x = 10'd207;
        bif.v_y = 10'd98;
        step();
        step();
        reset = 1'b0;
        // reset state
        expect_at(cyc, S_EX, 143);
        expect_at(cyc, S_EY, 34);
        expect_at(cyc, S_SCEN, 0);
        expect_at(cyc, S_BLAST, 0);
        expect_at(cyc, S_HIT, 0);
        expect_at(cyc, S_BOMB, 0);
        step();

        // Snap, phase timing and press filtering
        n = cyc;
        bif.b_x = 10'd200;
        bif.b_y = 10'd100;
        expect_at(n + 1, S_EX, 207);
        expect_at(n + 1, S_EY, 98);
        expect_at(n + 1, S_BOMB, 1);
        expect_at(n + 1, S_BLAST, 0);
        expect_at(n + 4, S_EX, 207);
        expect_at(n + 4, S_EY, 98);
        expect_at(n + 10, S_BLAST, 0);
        expect_at(n + 10, S_BOMB, 1);
        scen_q.push_back(n + 11);
        expect_at(n + 11, S_BLAST, 1);
        expect_at(n + 11, S_EXPL, 1);
        expect_at(n + 11, S_BOMB, 0);
        expect_at(n + 12, S_SCEN, 0);
        expect_at(n + 15, S_BLAST, 1);
        expect_at(n + 16, S_BLAST, 0);
        expect_at(n + 16, S_EXPL, 0);
        expect_at(n + 16, S_HIT, 0);
        expect_at(n + 18, S_BLAST, 0);
        expect_at(n + 18, S_BOMB, 0);
        expect_at(n + 21, S_EX, 207);
        expect_at(n + 21, S_BOMB, 0);
        expect_at(n + 23, S_BOMB, 0);
        expect_at(n + 23, S_BLAST, 0);
        press_now();
        wait_to(n + 3);
        bif.b_x = 10'd300;
        bif.b_y = 10'd300;
        press_now();                       // ignored during FUSE
        wait_to(n + 5);
        bif.b_x = 10'd207;                 // below the plus: no hit
        bif.b_y = 10'd180;
        wait_to(n + 14);
        bif.place_btn = 1'b1;              // held across return to IDLE
        wait_to(n + 18);
        bif.place_btn = 1'b0;
        wait_to(n + 19);
        bif.game_over = 1'b1;
        bif.b_x = 10'd400;
        bif.b_y = 10'd400;
        wait_to(n + 20);
        press_now();                       // lost under game_over
        wait_to(n + 22);
        bif.game_over = 1'b0;
        wait_to(n + 24);

        // Clamp at the far corner
        n = cyc;
        bif.b_x = 10'd790;
        bif.b_y = 10'd510;
        expect_at(n + 1, S_EX, 767);
        expect_at(n + 1, S_EY, 498);
        scen_q.push_back(n + 11);
        expect_at(n + 11, S_BLAST, 1);
        expect_at(n + 12, S_EXPL, 0);
        expect_at(n + 13, S_HIT, 0);
        press_now();
        bif.b_x = 10'd0;
        bif.b_y = 10'd0;
        wait_to(n + 17);

        // Player hit, sticky through IDLE
        n = cyc;
        bif.b_x = 10'd200;
        bif.b_y = 10'd100;
        expect_at(n + 1, S_EX, 207);
        expect_at(n + 1, S_EY, 98);
        scen_q.push_back(n + 11);
        expect_at(n + 11, S_HIT, 0);
        expect_at(n + 12, S_HIT, 1);
        expect_at(n + 20, S_HIT, 1);
        expect_at(n + 20, S_BLAST, 0);
        press_now();
        wait_to(n + 2);
        bif.b_x = 10'd247;
        bif.b_y = 10'd98;
        wait_to(n + 21);

        // Reset in mid-BLAST, then a full fresh sequence
        n = cyc;
        bif.b_x = 10'd200;
        bif.b_y = 10'd100;
        scen_q.push_back(n + 11);
        expect_at(n + 12, S_BLAST, 1);
        expect_at(n + 14, S_BLAST, 0);
        expect_at(n + 14, S_HIT, 0);
        expect_at(n + 14, S_EX, 143);
        expect_at(n + 14, S_EY, 34);
        expect_at(n + 14, S_SCEN, 0);
        expect_at(n + 15, S_BLAST, 0);
        press_now();
        wait_to(n + 13);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bif.b_x = 10'd300;
        bif.b_y = 10'd300;
        step();
        n = cyc;
        bif.b_x = 10'd200;
        bif.b_y = 10'd100;
        expect_at(n + 1, S_EX, 207);
        expect_at(n + 1, S_EY, 98);
        expect_at(n + 10, S_BLAST, 0);
        scen_q.push_back(n + 11);
        expect_at(n + 11, S_BLAST, 1);
        expect_at(n + 15, S_BLAST, 1);
        expect_at(n + 16, S_BLAST, 0);
        expect_at(n + 16, S_HIT, 0);
        press_now();
        bif.b_x = 10'd300;
        bif.b_y = 10'd300;
        wait_to(n + 18);
        @(negedge clk);
        #1;

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL exp_drain: got %0d pending, expected 0", exp_q.size());
        end
        tests++;
        if (scen_q.size() != 0) begin
            fails++;
            $display("FAIL scen_drain: got %0d missing strobes, expected 0", scen_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bomb_controller.md
# bomb_controller

Single-bomb placement and detonation controller for the Bomberman playfield. It latches a grid-snapped bomb position when the player presses the place button, then runs the fuse and blast phases on cycle counters. It drives the explosion centre and strobe consumed by every enemy instance, plus a sticky player-hit flag. It also flags VGA pixels inside the bomb sprite or the blast plus-shape for the top-level colour mux.

## Interface
Parameters:
- FUSE_CYCLES, 200_000_000 — cycles in FUSE (2 s at 100 MHz); must be ≥1
- BLAST_CYCLES, 50_000_000 — cycles in BLAST; must be ≥1
- CNT_W, 28 — phase counter width; must hold max(FUSE_CYCLES, BLAST_CYCLES)−1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset; one clock; all registers act on the rising edge of clk
- place_btn  in  1  debounced place-bomb level
- game_over  in  1  blocks new placements while high
- b_x, b_y  in  10  bomberman top-left pixel position
- v_x, v_y  in  10  current VGA pixel
- e_x, e_y  out  10  latched bomb/explosion top-left tile position
- explosion_SCEN  out  1  one-cycle strobe on first BLAST cycle
- blast_active  out  1  high for every BLAST cycle
- bomb_on  out  1  pixel inside 16×16 bomb tile during FUSE (combinational)
- explosion_on  out  1  pixel inside blast plus during BLAST (combinational)
- player_hit  out  1  sticky; bomberman overlapped blast

## Operation
- States: IDLE, FUSE, BLAST. Reset → IDLE, cnt=0, btn_prev=0, e_x=143, e_y=34, explosion_SCEN=0, player_hit=0.
- Press = place_btn & !btn_prev, evaluated in every state. btn_prev registers place_btn each cycle.
- IDLE: press & !game_over → latch snapped e_x/e_y, cnt←0, go FUSE. Otherwise stay.
- Snap (11-bit unsigned math): cx = (b_x+8 ≥ 143) ? (b_x+8−143)>>4 : 0, clamped to ≤39; e_x = 143+16·cx. cy = (b_y+8 ≥ 34) ? (b_y+8−34)>>4 : 0, clamped to ≤29; e_y = 34+16·cy.
- FUSE: cnt increments each cycle. At cnt==FUSE_CYCLES−1: cnt←0, go BLAST. Presses are ignored.
- BLAST: cnt increments each cycle. At cnt==BLAST_CYCLES−1: cnt←0, go IDLE. Presses are ignored. e_x/e_y hold until the next placement.
- Blast shape:
  - horizontal bar x∈[e_x−48, e_x+63], y∈[e_y, e_y+15]
  - vertical bar x∈[e_x, e_x+15], y∈[e_y−48, e_y+63]
  - Compare with offsets added on the opposite side (e.g. y+48 ≥ e_y), so nothing underflows.
- player_hit: set at the clock edge after any BLAST cycle in which box [b_x, b_x+15]×[b_y, b_y+15] intersects either bar (closed intervals). Cleared only by reset.
- game_over has no effect on a bomb already in flight.

## Timing
- Press seen in cycle N, in IDLE → from cycle N+1: state=FUSE, e_x/e_y valid, bomb_on may assert.
- First BLAST cycle = N+1+FUSE_CYCLES. explosion_SCEN is registered and high in exactly that cycle.
- blast_active high for cycles N+1+FUSE_CYCLES through N+FUSE_CYCLES+BLAST_CYCLES.
- Back in IDLE at N+1+FUSE_CYCLES+BLAST_CYCLES. A new press is accepted in that cycle at the earliest.
- A button held across the return to IDLE creates no press. A release and re-press is required.
- Press while game_over=1 is lost, not queued.
- Reset in any state takes effect at the next edge: all outputs return to reset values, and any active strobe or blast is aborted.
- bomb_on and explosion_on are zero-latency combinational functions of v_x, v_y and the registered state.

## Structure
- Shared package bomberman_pkg holds:
  - playfield bounds MIN_X=143, MAX_X=784, MIN_Y=34, MAX_Y=516
  - TILE=16; blast geometry E_WN=48, E_WP=63, E_HP=48, E_HN=63, E_Width=16
  - state encodings
- Enemy and bomberman modules use the same geometry constants.
- One combinational sub-module, blast_overlap: box (x, y, w, h) vs. plus at (e_x, e_y) → hit.
  - Instantiated twice: player box (w=h=16) and VGA pixel (w=h=1).

## Test plan
All scenarios use FUSE_CYCLES=10, BLAST_CYCLES=5.
- Reset: hold reset 2 cycles → state IDLE, e_x=143, e_y=34, explosion_SCEN=0, blast_active=0, player_hit=0.
- Snap: b_x=200, b_y=100, press at cycle N → e_x=207, e_y=98 at N+1. Then b_x=790, b_y=510 → e_x=767, e_y=498 (clamp).
- Phase timing: press at N → explosion_SCEN high only at N+11; blast_active high N+11..N+15; IDLE at N+16.
- Press filtering:
  - second press during FUSE → no re-latch, timing unchanged
  - button held through N+16 → stays IDLE
  - press with game_over=1 → stays IDLE
- Player hit: e_x=207, e_y=98, bomberman at (247, 98) during BLAST → player_hit=1 and stays 1 after IDLE. Bomberman at (207, 180) → stays 0.
- Reset mid-BLAST at N+13 → IDLE at N+14, blast_active=0, player_hit=0; a fresh press restarts the full sequence.
